// File: rtl/median_window_gen.sv
// Median filter front end: serial line samples in, one WINDOW_SIZE-wide window
// per sample out, centred on that sample, with edge replication at both line ends.
module median_window_gen #(
    parameter int NUMBER_WIDTH = 10,
    parameter int WINDOW_SIZE  = 9,
    parameter int LINE_LENGTH  = 640
) (
    input  logic                                      clk_i,
    input  logic                                      rst_i,
    input  logic                                      sample_valid_i,
    output logic                                      sample_ready_o,
    input  logic [NUMBER_WIDTH-1:0]                   sample_i,
    output logic                                      window_valid_o,
    output logic                                      window_last_o,
    output logic [WINDOW_SIZE-1:0][NUMBER_WIDTH-1:0]  window_o
);

    localparam int HALF = (WINDOW_SIZE - 1) / 2;
    localparam int CW   = (LINE_LENGTH > 1) ? $clog2(LINE_LENGTH) : 1;
    localparam int FW   = (HALF > 0) ? $clog2(HALF + 1) : 1;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t                                     r_state;
    logic [CW-1:0]                              r_col;
    logic [FW-1:0]                              r_fcnt;
    logic [WINDOW_SIZE-1:0][NUMBER_WIDTH-1:0]   r_win;
    logic                                       r_valid;
    logic                                       r_last;

    logic                                       w_accept;
    logic [NUMBER_WIDTH-1:0]                    w_in;
    logic [WINDOW_SIZE-1:0][NUMBER_WIDTH-1:0]   w_shifted;

    // Ready depends on state only; flush cycles are the only stall.
    assign sample_ready_o = (r_state != FLUSH);
    assign w_accept       = sample_valid_i && sample_ready_o;

    // Flush replicates the newest sample to build the right edge.
    assign w_in      = (r_state == FLUSH) ? r_win[WINDOW_SIZE-1] : sample_i;
    assign w_shifted = {w_in, r_win[WINDOW_SIZE-1:1]};

    // Line sequencer: fill half a window, emit one window per accept, then flush.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= FILL;
            r_col   <= '0;
            r_fcnt  <= '0;
            r_win   <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            case (r_state)
                FILL: begin
                    if (w_accept) begin
                        // First column seeds the whole window for left replication.
                        if (r_col == '0)
                            r_win <= {WINDOW_SIZE{sample_i}};
                        else
                            r_win <= w_shifted;
                        r_col <= r_col + 1'b1;
                        if (r_col == CW'(HALF - 1))
                            r_state <= RUN;
                    end
                end
                RUN: begin
                    if (w_accept) begin
                        r_win   <= w_shifted;
                        r_valid <= 1'b1;
                        if (r_col == CW'(LINE_LENGTH - 1)) begin
                            r_col   <= '0;
                            r_fcnt  <= '0;
                            r_state <= FLUSH;
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    r_win   <= w_shifted;
                    r_valid <= 1'b1;
                    r_fcnt  <= r_fcnt + 1'b1;
                    if (r_fcnt == FW'(HALF - 1)) begin
                        r_last  <= 1'b1;
                        r_state <= FILL;
                    end
                end
                default: r_state <= FILL;
            endcase
        end
    end

    assign window_valid_o = r_valid;
    assign window_last_o  = r_last;
    assign window_o       = r_win;

endmodule

// File: tb/tb_median_window_gen.sv
// Directed bench for median_window_gen with N=5, HALF=2, LINE_LENGTH=8.
module tb_median_window_gen;

    localparam int NW   = 10;
    localparam int N    = 5;
    localparam int HALF = 2;
    localparam int LL   = 8;

    logic                    clk_i = 1'b0;
    logic                    rst_i;
    logic                    sample_valid_i;
    logic                    sample_ready_o;
    logic [NW-1:0]           sample_i;
    logic                    window_valid_o;
    logic                    window_last_o;
    logic [N-1:0][NW-1:0]    window_o;

    int n_vec = 0;
    int n_err = 0;

    median_window_gen #(.NUMBER_WIDTH(NW), .WINDOW_SIZE(N), .LINE_LENGTH(LL)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .sample_valid_i (sample_valid_i),
        .sample_ready_o (sample_ready_o),
        .sample_i       (sample_i),
        .window_valid_o (window_valid_o),
        .window_last_o  (window_last_o),
        .window_o       (window_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Pack five sample values, leftmost first, into the window layout.
    function automatic logic [N-1:0][NW-1:0] pk(input int a, b, c, d, e);
        logic [N-1:0][NW-1:0] w;
        w[0] = NW'(a); w[1] = NW'(b); w[2] = NW'(c); w[3] = NW'(d); w[4] = NW'(e);
        return w;
    endfunction

    // Expected window k of a line whose column j holds scale*(j+1).
    function automatic logic [N-1:0][NW-1:0] exp_win(input int scale, input int k);
        logic [N-1:0][NW-1:0] w;
        int idx;
        for (int i = 0; i < N; i++) begin
            idx = k - HALF + i;
            if (idx < 0) idx = 0;
            if (idx > LL - 1) idx = LL - 1;
            w[i] = NW'(scale * (idx + 1));
        end
        return w;
    endfunction

    task automatic step;
        @(posedge clk_i);
        #1;
    endtask

    // Feed one line; optional gap cycle before every sample; optional 99 held during flush.
    task automatic run_line(input int scale, input bit gap, input bit hold99);
        int k;
        logic [N-1:0][NW-1:0] prev;
        k = 0;
        for (int j = 0; j < LL; j++) begin
            if (gap) begin
                prev = window_o;
                sample_valid_i = 1'b0;
                sample_i = NW'(777);
                step();
                chk("gap_no_valid", 64'(window_valid_o), 64'd0);
                chk("gap_hold_win", 64'(window_o), 64'(prev));
            end
            sample_valid_i = 1'b1;
            sample_i = NW'(scale * (j + 1));
            step();
            if (j >= HALF) begin
                chk($sformatf("run_valid_k%0d", k), 64'(window_valid_o), 64'd1);
                chk($sformatf("run_win_k%0d", k), 64'(window_o), 64'(exp_win(scale, k)));
                chk("run_last", 64'(window_last_o), 64'd0);
                k++;
            end else begin
                chk("fill_no_valid", 64'(window_valid_o), 64'd0);
            end
            chk("ready_after_accept", 64'(sample_ready_o), (j == LL - 1) ? 64'd0 : 64'd1);
        end
        for (int f = 0; f < HALF; f++) begin
            sample_valid_i = hold99 ? 1'b1 : (gap ? f[0] : 1'b0);
            sample_i = NW'(99);
            step();
            chk($sformatf("flush_valid_k%0d", k), 64'(window_valid_o), 64'd1);
            chk($sformatf("flush_win_k%0d", k), 64'(window_o), 64'(exp_win(scale, k)));
            chk("flush_last", 64'(window_last_o), (k == LL - 1) ? 64'd1 : 64'd0);
            chk("flush_ready", 64'(sample_ready_o), (f == HALF - 1) ? 64'd1 : 64'd0);
            k++;
        end
        sample_valid_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1;
        sample_valid_i = 1'b0;
        sample_i = '0;
        #2;
        chk("rst_ready", 64'(sample_ready_o), 64'd1);
        chk("rst_valid", 64'(window_valid_o), 64'd0);
        chk("rst_last", 64'(window_last_o), 64'd0);
        chk("rst_win", 64'(window_o), 64'd0);
        step();
        step();
        rst_i = 1'b0;
        step();
        chk("idle_valid", 64'(window_valid_o), 64'd0);

        // Line 1, continuous; spot-check hand-derived windows.
        sample_valid_i = 1'b1; sample_i = 10; step();
        chk("t1_no_win_10", 64'(window_valid_o), 64'd0);
        sample_i = 20; step();
        chk("t1_no_win_20", 64'(window_valid_o), 64'd0);
        sample_i = 30; step();
        chk("t1_k0_valid", 64'(window_valid_o), 64'd1);
        chk("t1_k0", 64'(window_o), 64'(pk(10, 10, 10, 20, 30)));
        sample_i = 40; step();
        chk("t1_k1", 64'(window_o), 64'(pk(10, 10, 20, 30, 40)));
        for (int v = 50; v <= 70; v += 10) begin
            sample_i = NW'(v); step();
        end
        sample_i = 80; step();
        chk("t1_k5", 64'(window_o), 64'(pk(40, 50, 60, 70, 80)));
        chk("t1_ready_low1", 64'(sample_ready_o), 64'd0);
        sample_valid_i = 1'b0; step();
        chk("t1_k6", 64'(window_o), 64'(pk(50, 60, 70, 80, 80)));
        chk("t1_k6_last", 64'(window_last_o), 64'd0);
        chk("t1_ready_low2", 64'(sample_ready_o), 64'd0);
        step();
        chk("t1_k7", 64'(window_o), 64'(pk(60, 70, 80, 80, 80)));
        chk("t1_k7_last", 64'(window_last_o), 64'd1);
        chk("t1_ready_back", 64'(sample_ready_o), 64'd1);
        step();
        chk("t1_idle_valid", 64'(window_valid_o), 64'd0);
        chk("t1_idle_hold", 64'(window_o), 64'(pk(60, 70, 80, 80, 80)));

        // Two lines back-to-back; second line must not see first line data.
        run_line(10, 1'b0, 1'b0);
        run_line(1, 1'b0, 1'b0);

        // Valid toggling every cycle.
        run_line(10, 1'b1, 1'b0);

        // Valid held with 99 during flush, next line starts right after.
        run_line(10, 1'b0, 1'b1);
        run_line(1, 1'b0, 1'b0);

        // Asynchronous reset mid-line.
        for (int j = 0; j < 5; j++) begin
            sample_valid_i = 1'b1;
            sample_i = NW'(10 * (j + 1));
            step();
        end
        chk("t6_pre_valid", 64'(window_valid_o), 64'd1);
        sample_valid_i = 1'b0;
        #2 rst_i = 1'b1;
        #1;
        chk("t6_rst_valid", 64'(window_valid_o), 64'd0);
        chk("t6_rst_win", 64'(window_o), 64'd0);
        chk("t6_rst_ready", 64'(sample_ready_o), 64'd1);
        #1 rst_i = 1'b0;
        step();
        chk("t6_idle_valid", 64'(window_valid_o), 64'd0);
        run_line(10, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
